// File: rtl/riscy_io_pkg.sv
// Shared register map, event word layout and STATUS field layout for the
// button event port and its software-visible registers.
package riscy_io_pkg;

    localparam int NUM_BUTTONS = 3;

    typedef enum logic [2:0] {
        OFF_STATE  = 3'b100,
        OFF_EVENT  = 3'b101,
        OFF_STATUS = 3'b110,
        OFF_CTRL   = 3'b111
    } reg_off_e;

    localparam int EVT_VALID_BIT = 31;
    localparam int EVT_PRESS_BIT = 2;
    localparam int EVT_IDX_LSB   = 0;
    localparam int EVT_IDX_W     = 2;
    localparam int EVT_TS_LSB    = 8;
    localparam int EVT_TS_W      = 16;

    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 4;
    localparam int STATUS_OVF_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 0;

    function automatic logic [31:0] make_event(input logic [EVT_IDX_W-1:0] idx,
                                               input logic                 press,
                                               input logic [EVT_TS_W-1:0]  ts);
        logic [31:0] w;
        w = '0;
        w[EVT_VALID_BIT]                = 1'b1;
        w[EVT_PRESS_BIT]                = press;
        w[EVT_IDX_LSB +: EVT_IDX_W]     = idx;
        w[EVT_TS_LSB +: EVT_TS_W]       = ts;
        return w;
    endfunction

endpackage

// File: rtl/button_event_port_if.sv
// Register bus between the IO region decoder (master) and the button event port (slave).
interface button_event_port_if;
    logic        SEL;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [4:0]  WMASK;
    logic        RD;
    logic [31:0] rdata;

    modport master (output SEL, ADDR, WDATA, WMASK, RD, input rdata);
    modport slave  (input SEL, ADDR, WDATA, WMASK, RD, output rdata);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counter debounce for one button; emits one-cycle
// registered pulses when the accepted (stable) level rises or falls.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             differs;
    logic             accept;

    assign differs = (sync2_reg != stable_reg);
    // The new level is taken on the Nth consecutive differing cycle.
    assign accept  = differs && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= btn_async;
            sync2_reg <= sync1_reg;
            rise_reg  <= accept & sync2_reg;
            fall_reg  <= accept & ~sync2_reg;
            if (accept) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else if (differs) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;
endmodule

// File: rtl/button_event_port.sv
// Debounced three-button event port with an event FIFO and STATE/EVENT/STATUS/CTRL registers.
// Optional macro BUTTON_EVENT_TIMESTAMP_EN stamps each event with a 16-bit cycle counter.
module button_event_port
    import riscy_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [NUM_BUTTONS-1:0]    BUTTONS,
    button_event_port_if.slave        bus,
    output logic                      irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk       (CLK),
            .rst_n     (RESET_N),
            .btn_async (BUTTONS[gi]),
            .stable    (stable[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

    logic [NUM_BUTTONS-1:0] pend_press_reg;
    logic [NUM_BUTTONS-1:0] pend_rel_reg;
    logic [NUM_BUTTONS-1:0] grant_oh;
    logic [EVT_IDX_W-1:0]   grant_idx;
    logic                   grant_any;
    logic                   grant_press;

    // Lowest button index wins; a button with both edges pending reports its press first.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_any   = 1'b0;
        grant_press = 1'b0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pend_press_reg[i] || pend_rel_reg[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = EVT_IDX_W'(i);
                grant_any   = 1'b1;
                grant_press = pend_press_reg[i];
            end
        end
    end

    logic [EVT_TS_W-1:0] ts_now;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [EVT_TS_W-1:0] ts_reg;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) ts_reg <= '0;
        else          ts_reg <= ts_reg + 1'b1;
    end
    assign ts_now = ts_reg;
`else
    assign ts_now = '0;
`endif

    logic [31:0] event_word;
    assign event_word = make_event(grant_idx, grant_press, ts_now);

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic             irq_en_reg;
    logic [31:0]      rdata_reg;

    logic [2:0] offset;
    logic       rd_hit;
    logic       wr_hit;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push;
    logic       do_write;
    logic       ovf_set;

    assign offset     = bus.ADDR[4:2];
    assign rd_hit     = bus.SEL & bus.RD;
    assign wr_hit     = bus.SEL & bus.WMASK[0];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop        = rd_hit && (offset == OFF_EVENT) && !fifo_empty;
    assign push       = grant_any;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_write   = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;

    always_ff @(posedge CLK) begin
        if (do_write) mem[wr_ptr_reg] <= event_word;
    end

    logic [31:0] rd_data_next;
    always_comb begin
        rd_data_next = '0;
        case (offset)
            OFF_STATE:  rd_data_next[NUM_BUTTONS-1:0] = stable;
            OFF_EVENT:  rd_data_next = fifo_empty ? 32'd0 : mem[rd_ptr_reg];
            OFF_STATUS: begin
                rd_data_next[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(count_reg);
                rd_data_next[STATUS_OVF_BIT]                     = ovf_reg;
            end
            OFF_CTRL:   rd_data_next[CTRL_IRQ_EN_BIT] = irq_en_reg;
            default:    rd_data_next = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_press_reg <= '0;
            pend_rel_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ovf_reg        <= 1'b0;
            irq_en_reg     <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            // A granted edge is consumed whether it was stored or dropped on overflow.
            pend_press_reg <= (pend_press_reg & ~(grant_press  ? grant_oh : '0)) | rise;
            pend_rel_reg   <= (pend_rel_reg   & ~(!grant_press ? grant_oh : '0)) | fall;

            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_write, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (ovf_set)
                ovf_reg <= 1'b1;
            else if (wr_hit && (offset == OFF_STATUS) && bus.WDATA[STATUS_OVF_BIT])
                ovf_reg <= 1'b0;

            if (wr_hit && (offset == OFF_CTRL))
                irq_en_reg <= bus.WDATA[CTRL_IRQ_EN_BIT];

            if (rd_hit) rdata_reg <= rd_data_next;
        end
    end

    assign bus.rdata = rdata_reg;
    assign irq       = irq_en_reg & ~fifo_empty;

    logic unused_bits;
    assign unused_bits = ^{bus.ADDR[31:5], bus.ADDR[1:0], bus.WDATA[31:1], bus.WMASK[4:1]};
endmodule
